// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: hazard controls, branch
// redirect, instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if #(
    parameter int DATA_W = 22,
    parameter int CNT_W  = 16
);
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              branch_taken_e;
    logic [DATA_W-1:0] branch_target_e;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rd;
    logic [DATA_W-1:0] pc_f;
    logic [DATA_W-1:0] instr_d;
    logic [DATA_W-1:0] pc_plus4_d;
    logic              valid_d;
    logic              fetch_fault;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  stall_f, stall_d, flush_d, branch_taken_e, branch_target_e, imem_rd,
        output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, fetch_fault, fetch_count
    );

    modport slave (
        output stall_f, stall_d, flush_d, branch_taken_e, branch_target_e, imem_rd,
        input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, fetch_fault, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and fills the IF/ID register, handling stalls, flushes and redirects.
module fetch_stage #(
    parameter int                DATA_W    = 22,
    parameter int                MEM_WORDS = 101,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    // One spare bit so a memory of exactly 2^(DATA_W-2) words is representable.
    localparam logic [DATA_W-2:0] MEM_LIMIT = (DATA_W-1)'(MEM_WORDS);
    localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] target_aligned;
    logic              in_range;
    logic              target_in_range;
    logic              capture;

    assign pc_plus4        = pc_q + DATA_W'(4);
    assign target_aligned  = bus.branch_target_e & ALIGN_MASK;
    assign in_range        = {1'b0, pc_q[DATA_W-1:2]} < MEM_LIMIT;
    assign target_in_range = {1'b0, target_aligned[DATA_W-1:2]} < MEM_LIMIT;

    // A redirect wins over everything, including stall_f.
    always_comb begin
        pc_d = pc_q;
        if (bus.branch_taken_e) begin
            pc_d = target_aligned;
        end else if (!bus.stall_f && in_range) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        capture = 1'b0;
        if (bus.branch_taken_e || bus.flush_d) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (bus.stall_d) begin
            instr_d = instr_q;
        end else if (!in_range) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else begin
            instr_d = bus.imem_rd;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            capture = 1'b1;
        end
    end

    always_comb begin
        fault_d = fault_q;
        if (bus.branch_taken_e) begin
            if (target_in_range) begin
                fault_d = 1'b0;
            end
        end else if (!in_range) begin
            fault_d = 1'b1;
        end
    end

    assign cnt_d = (capture && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc_f        = pc_q;
    assign bus.instr_d     = instr_q;
    assign bus.pc_plus4_d  = pc4_q;
    assign bus.valid_d     = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 101-word and a 4-word instance, expected
// IF/ID state queued with each step and compared after the clock edge.
module tb_fetch_stage;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    typedef struct {
        logic [21:0] pc;
        logic [21:0] instr;
        logic        valid;
        logic [21:0] p4;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    fetch_stage_if #(.DATA_W(22), .CNT_W(16)) ia ();
    fetch_stage_if #(.DATA_W(22), .CNT_W(16)) ib ();

    fetch_stage #(.DATA_W(22), .MEM_WORDS(101), .NOP_INSTR(22'b0), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.master)
    );

    fetch_stage #(.DATA_W(22), .MEM_WORDS(4), .NOP_INSTR(22'b0), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.master)
    );

    function automatic logic [21:0] w(input int i);
        return 22'(32'h15000 + 33 * i + 1);
    endfunction

    assign ia.imem_rd = w(int'(ia.imem_addr[21:2]));
    assign ib.imem_rd = w(int'(ib.imem_addr[21:2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [21:0] pc, input logic [21:0] instr, input logic valid,
                                input logic [21:0] p4, input logic fault, input logic [15:0] cnt);
        exp_t e;
        e.pc = pc; e.instr = instr; e.valid = valid; e.p4 = p4; e.fault = fault; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input bit sel, input string tag, input exp_t e);
        if (sel) begin
            chk({tag, ".pc"},    32'(ib.pc_f),        32'(e.pc));
            chk({tag, ".addr"},  32'(ib.imem_addr),   32'(e.pc));
            chk({tag, ".instr"}, 32'(ib.instr_d),     32'(e.instr));
            chk({tag, ".valid"}, 32'(ib.valid_d),     32'(e.valid));
            chk({tag, ".p4"},    32'(ib.pc_plus4_d),  32'(e.p4));
            chk({tag, ".fault"}, 32'(ib.fetch_fault), 32'(e.fault));
            chk({tag, ".cnt"},   32'(ib.fetch_count), 32'(e.cnt));
            $display("step %s pc=%h instr=%h valid=%0d p4=%h fault=%0d cnt=%0d", tag,
                     ib.pc_f, ib.instr_d, ib.valid_d, ib.pc_plus4_d, ib.fetch_fault, ib.fetch_count);
        end else begin
            chk({tag, ".pc"},    32'(ia.pc_f),        32'(e.pc));
            chk({tag, ".addr"},  32'(ia.imem_addr),   32'(e.pc));
            chk({tag, ".instr"}, 32'(ia.instr_d),     32'(e.instr));
            chk({tag, ".valid"}, 32'(ia.valid_d),     32'(e.valid));
            chk({tag, ".p4"},    32'(ia.pc_plus4_d),  32'(e.p4));
            chk({tag, ".fault"}, 32'(ia.fetch_fault), 32'(e.fault));
            chk({tag, ".cnt"},   32'(ia.fetch_count), 32'(e.cnt));
            $display("step %s pc=%h instr=%h valid=%0d p4=%h fault=%0d cnt=%0d", tag,
                     ia.pc_f, ia.instr_d, ia.valid_d, ia.pc_plus4_d, ia.fetch_fault, ia.fetch_count);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input bit sel, input string tag, input logic sf, input logic sd,
                        input logic fl, input logic br, input logic [21:0] tgt, input exp_t e);
        exp_t got;
        if (sel) begin
            ib.stall_f = sf; ib.stall_d = sd; ib.flush_d = fl;
            ib.branch_taken_e = br; ib.branch_target_e = tgt;
        end else begin
            ia.stall_f = sf; ia.stall_d = sd; ia.flush_d = fl;
            ia.branch_taken_e = br; ia.branch_target_e = tgt;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp(sel, tag, got);
    endtask

    task automatic reset_a(input string tag);
        rst_a = 1'b1;
        #1;
        cmp(1'b0, tag, mk(22'h0, 22'h0, 1'b0, 22'h0, 1'b0, 16'd0));
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.stall_f = 0; ia.stall_d = 0; ia.flush_d = 0; ia.branch_taken_e = 0; ia.branch_target_e = '0;
        ib.stall_f = 0; ib.stall_d = 0; ib.flush_d = 0; ib.branch_taken_e = 0; ib.branch_target_e = '0;
        @(posedge clk);
        #1;
        cmp(1'b0, "rst0", mk(22'h0, 22'h0, 1'b0, 22'h0, 1'b0, 16'd0));
        rst_a = 1'b0;

        // Free run: pc 4,8,12,16 with words A..D in IF/ID.
        step(0, "free1", 0, 0, 0, 0, 0, mk(22'd4,  w(0), 1, 22'd4,  0, 16'd1));
        step(0, "free2", 0, 0, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(0, "free3", 0, 0, 0, 0, 0, mk(22'd12, w(2), 1, 22'd12, 0, 16'd3));
        step(0, "free4", 0, 0, 0, 0, 0, mk(22'd16, w(3), 1, 22'd16, 0, 16'd4));

        // Stall both at pc=8, then release, then redirect under stall.
        reset_a("rst1");
        step(0, "s_a",   0, 0, 0, 0, 0, mk(22'd4,  w(0), 1, 22'd4,  0, 16'd1));
        step(0, "s_b",   0, 0, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(0, "stl1",  1, 1, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(0, "stl2",  1, 1, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(0, "rel",   0, 0, 0, 0, 0, mk(22'd12, w(2), 1, 22'd12, 0, 16'd3));
        step(0, "br",    1, 1, 0, 1, 22'h16, mk(22'h14, 22'h0, 0, 22'h0, 0, 16'd3));
        step(0, "br_nx", 0, 0, 0, 0, 0, mk(22'h18, w(5), 1, 22'h18, 0, 16'd4));

        // Flush alone at pc=8.
        reset_a("rst2");
        step(0, "f_a",   0, 0, 0, 0, 0, mk(22'd4,  w(0), 1, 22'd4,  0, 16'd1));
        step(0, "f_b",   0, 0, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(0, "flush", 0, 0, 1, 0, 0, mk(22'd12, 22'h0, 0, 22'h0, 0, 16'd2));
        step(0, "fl_nx", 0, 0, 0, 0, 0, mk(22'd16, w(3), 1, 22'd16, 0, 16'd3));

        // stall_f without stall_d: same PC re-captured.
        reset_a("rst3");
        step(0, "sf_a",  0, 0, 0, 0, 0, mk(22'd4, w(0), 1, 22'd4, 0, 16'd1));
        step(0, "sfonl", 1, 0, 0, 0, 0, mk(22'd4, w(1), 1, 22'd8, 0, 16'd2));
        step(0, "sfon2", 1, 0, 0, 0, 0, mk(22'd4, w(1), 1, 22'd8, 0, 16'd3));

        // Async reset mid-cycle while stalled at pc=8.
        reset_a("rst4");
        step(0, "r_a",   0, 0, 0, 0, 0, mk(22'd4, w(0), 1, 22'd4, 0, 16'd1));
        step(0, "r_b",   0, 0, 0, 0, 0, mk(22'd8, w(1), 1, 22'd8, 0, 16'd2));
        ia.stall_f = 1'b1;
        #3;
        rst_a = 1'b1;
        #1;
        cmp(1'b0, "rst_mid", mk(22'h0, 22'h0, 1'b0, 22'h0, 1'b0, 16'd0));
        #1;
        rst_a = 1'b0;
        step(0, "r_rel", 0, 0, 0, 0, 0, mk(22'd4, w(0), 1, 22'd4, 0, 16'd1));

        // Four-word memory: run off the end, fault, recover by branching.
        rst_b = 1'b0;
        step(1, "m4_1",  0, 0, 0, 0, 0, mk(22'd4,  w(0), 1, 22'd4,  0, 16'd1));
        step(1, "m4_2",  0, 0, 0, 0, 0, mk(22'd8,  w(1), 1, 22'd8,  0, 16'd2));
        step(1, "m4_3",  0, 0, 0, 0, 0, mk(22'd12, w(2), 1, 22'd12, 0, 16'd3));
        step(1, "m4_4",  0, 0, 0, 0, 0, mk(22'd16, w(3), 1, 22'd16, 0, 16'd4));
        step(1, "m4_5",  0, 0, 0, 0, 0, mk(22'd16, 22'h0, 0, 22'h0, 1, 16'd4));
        step(1, "m4_6",  0, 0, 0, 0, 0, mk(22'd16, 22'h0, 0, 22'h0, 1, 16'd4));
        step(1, "m4_br", 0, 0, 0, 1, 22'h0, mk(22'd0, 22'h0, 0, 22'h0, 0, 16'd4));
        step(1, "m4_7",  0, 0, 0, 0, 0, mk(22'd4,  w(0), 1, 22'd4,  0, 16'd5));
        // Redirect out of range: fault only appears on the following edge.
        step(1, "m4_bo", 0, 0, 0, 1, 22'h40, mk(22'h40, 22'h0, 0, 22'h0, 0, 16'd5));
        step(1, "m4_8",  0, 0, 0, 0, 0, mk(22'h40, 22'h0, 0, 22'h0, 1, 16'd5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
